// File: rtl/w0rm_peripheral_bus_arbiter_pkg.sv
// Shared definitions for the W0RM peripheral bus arbiter: FSM state
// encoding, default bus geometry and response-timeout defaults.
package w0rm_bus_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TIMEOUT    = 16;

    // Legal TIMEOUT range; the wait counter is 8 bits wide.
    localparam int TIMEOUT_MIN    = 2;
    localparam int TIMEOUT_MAX    = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // A request must be exactly one of read or write; anything else is
    // answered locally with an error and never reaches the slave.
    function automatic logic is_illegal_op(input logic rd, input logic wr);
        return rd == wr;
    endfunction

endpackage

// File: rtl/w0rm_peripheral_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the downstream
// slave tree. The arbiter takes the 'slave' modport (it is the target
// of the masters); the environment (masters plus downstream slave)
// takes the 'master' modport.
interface w0rm_peripheral_bus_arbiter_if
    import w0rm_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  m0_valid_i;
    logic                  m0_read_i;
    logic                  m0_write_i;
    logic [ADDR_WIDTH-1:0] m0_addr_i;
    logic [DATA_WIDTH-1:0] m0_data_i;
    logic                  m0_ready_o;
    logic                  m0_valid_o;
    logic [DATA_WIDTH-1:0] m0_data_o;
    logic                  m0_error_o;

    logic                  m1_valid_i;
    logic                  m1_read_i;
    logic                  m1_write_i;
    logic [ADDR_WIDTH-1:0] m1_addr_i;
    logic [DATA_WIDTH-1:0] m1_data_i;
    logic                  m1_ready_o;
    logic                  m1_valid_o;
    logic [DATA_WIDTH-1:0] m1_data_o;
    logic                  m1_error_o;

    logic                  s_valid_o;
    logic                  s_read_o;
    logic                  s_write_o;
    logic [ADDR_WIDTH-1:0] s_addr_o;
    logic [DATA_WIDTH-1:0] s_data_o;
    logic                  s_valid_i;
    logic [DATA_WIDTH-1:0] s_data_i;

    modport slave (
        input  m0_valid_i, m0_read_i, m0_write_i, m0_addr_i, m0_data_i,
        output m0_ready_o, m0_valid_o, m0_data_o, m0_error_o,
        input  m1_valid_i, m1_read_i, m1_write_i, m1_addr_i, m1_data_i,
        output m1_ready_o, m1_valid_o, m1_data_o, m1_error_o,
        output s_valid_o, s_read_o, s_write_o, s_addr_o, s_data_o,
        input  s_valid_i, s_data_i
    );

    modport master (
        output m0_valid_i, m0_read_i, m0_write_i, m0_addr_i, m0_data_i,
        input  m0_ready_o, m0_valid_o, m0_data_o, m0_error_o,
        output m1_valid_i, m1_read_i, m1_write_i, m1_addr_i, m1_data_i,
        input  m1_ready_o, m1_valid_o, m1_data_o, m1_error_o,
        input  s_valid_o, s_read_o, s_write_o, s_addr_o, s_data_o,
        output s_valid_i, s_data_i
    );

endinterface

// File: rtl/w0rm_peripheral_bus_arbiter_rr.sv
// Two-requester round-robin grant. Grant is combinational and only
// produced while enabled; the last-grant pointer moves only when a
// grant is actually given, so a requester that withdraws before being
// served does not disturb the rotation.
module w0rm_rr_arbiter_2 (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_enable,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);
    // 1 = requester 1 won most recently; reset value lets requester 0
    // win the first tie.
    logic       r_last;
    logic [1:0] w_grant;

    // One-hot grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        w_grant = 2'b00;
        if (i_enable) begin
            case (i_req)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign o_grant = w_grant;

    // Record the winner on every grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (w_grant != 2'b00) begin
            r_last <= w_grant[1];
        end
    end

endmodule

// File: rtl/w0rm_peripheral_bus_arbiter.sv
// Two-master front end for the W0RM peripheral bus. Serialises requests
// from m0/m1 onto a single slave port, one transaction in flight, with
// round-robin arbitration and a response timeout.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; ready driven to the granted master
// ISSUE | one-cycle strobe of the captured request on the slave port
// WAIT  | waiting for s_valid_i; wait counter runs toward the timeout
// RESP  | one-cycle response pulse to the master that was granted
module w0rm_peripheral_bus_arbiter
    import w0rm_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          mem_clk,
    input  logic                          cpu_reset_n,
    w0rm_peripheral_bus_arbiter_if.slave  bus
);

    // Final WAIT count; the counter is 8 bits, which bounds TIMEOUT to 255.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    arb_state_t            r_state;
    logic                  r_gnt;
    logic [7:0]            r_wait_cnt;

    logic                  r_s_valid;
    logic                  r_s_read;
    logic                  r_s_write;
    logic [ADDR_WIDTH-1:0] r_s_addr;
    logic [DATA_WIDTH-1:0] r_s_data;

    logic                  r_m0_valid;
    logic                  r_m1_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_error;

    logic                  w_idle;
    logic [1:0]            w_req;
    logic [1:0]            w_grant;
    logic                  w_grant_any;
    logic                  w_gnt_idx;
    logic                  w_req_read;
    logic                  w_req_write;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    logic [DATA_WIDTH-1:0] w_req_data;

    // Ready is combinational, so it is also gated by reset to keep every
    // output low while cpu_reset_n is asserted.
    assign w_idle = (r_state == ST_IDLE) && cpu_reset_n;
    assign w_req  = {bus.m1_valid_i, bus.m0_valid_i};

    w0rm_rr_arbiter_2 u_rr (
        .i_clk    (mem_clk),
        .i_rst_n  (cpu_reset_n),
        .i_enable (w_idle),
        .i_req    (w_req),
        .o_grant  (w_grant)
    );

    assign w_grant_any = |w_grant;
    assign w_gnt_idx   = w_grant[1];
    assign w_req_read  = w_gnt_idx ? bus.m1_read_i  : bus.m0_read_i;
    assign w_req_write = w_gnt_idx ? bus.m1_write_i : bus.m0_write_i;
    assign w_req_addr  = w_gnt_idx ? bus.m1_addr_i  : bus.m0_addr_i;
    assign w_req_data  = w_gnt_idx ? bus.m1_data_i  : bus.m0_data_i;

    assign bus.m0_ready_o = w_grant[0];
    assign bus.m1_ready_o = w_grant[1];

    // Response data/error are forced to zero for a master that is not
    // being answered this cycle.
    assign bus.m0_valid_o = r_m0_valid;
    assign bus.m0_data_o  = r_m0_valid ? r_rsp_data : '0;
    assign bus.m0_error_o = r_m0_valid & r_rsp_error;
    assign bus.m1_valid_o = r_m1_valid;
    assign bus.m1_data_o  = r_m1_valid ? r_rsp_data : '0;
    assign bus.m1_error_o = r_m1_valid & r_rsp_error;

    assign bus.s_valid_o  = r_s_valid;
    assign bus.s_read_o   = r_s_read;
    assign bus.s_write_o  = r_s_write;
    assign bus.s_addr_o   = r_s_addr;
    assign bus.s_data_o   = r_s_data;

    // Transaction FSM with all slave strobes and response outputs registered.
    always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 1'b0;
            r_wait_cnt  <= 8'd0;
            r_s_valid   <= 1'b0;
            r_s_read    <= 1'b0;
            r_s_write   <= 1'b0;
            r_s_addr    <= '0;
            r_s_data    <= '0;
            r_m0_valid  <= 1'b0;
            r_m1_valid  <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_gnt <= w_gnt_idx;
                        if (is_illegal_op(w_req_read, w_req_write)) begin
                            // Malformed request: answer straight away, slave untouched.
                            r_state     <= ST_RESP;
                            r_rsp_data  <= '0;
                            r_rsp_error <= 1'b1;
                            r_m0_valid  <= ~w_gnt_idx;
                            r_m1_valid  <= w_gnt_idx;
                        end else begin
                            r_state   <= ST_ISSUE;
                            r_s_valid <= 1'b1;
                            r_s_read  <= w_req_read;
                            r_s_write <= w_req_write;
                            r_s_addr  <= w_req_addr;
                            r_s_data  <= w_req_data;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_state    <= ST_WAIT;
                    r_wait_cnt <= 8'd0;
                    r_s_valid  <= 1'b0;
                    r_s_read   <= 1'b0;
                    r_s_write  <= 1'b0;
                    r_s_addr   <= '0;
                    r_s_data   <= '0;
                end

                ST_WAIT: begin
                    // A response arriving on the last counted cycle still wins.
                    if (bus.s_valid_i) begin
                        r_state     <= ST_RESP;
                        r_wait_cnt  <= 8'd0;
                        r_rsp_data  <= bus.s_data_i;
                        r_rsp_error <= 1'b0;
                        r_m0_valid  <= ~r_gnt;
                        r_m1_valid  <= r_gnt;
                    end else if (r_wait_cnt == TO_LAST) begin
                        r_state     <= ST_RESP;
                        r_wait_cnt  <= 8'd0;
                        r_rsp_data  <= '0;
                        r_rsp_error <= 1'b1;
                        r_m0_valid  <= ~r_gnt;
                        r_m1_valid  <= r_gnt;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_m0_valid  <= 1'b0;
                    r_m1_valid  <= 1'b0;
                    r_rsp_data  <= '0;
                    r_rsp_error <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/w0rm_peripheral_bus_arbiter.md
W0RM_PERIPHERAL_BUS_ARBITER -- requirements
Module: w0rm_peripheral_bus_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width of all ports.
REQ-003 Parameter TIMEOUT, default 16, WAIT cycles without slave response before an error response; legal range 2..255.
REQ-004 mem_clk  input  1  sole clock; all logic rising-edge.
REQ-005 cpu_reset_n  input  1  asynchronous, active-low reset.
REQ-006 m0_valid_i, m1_valid_i  input  1  master request valid; held until matching ready.
REQ-007 m0_read_i, m1_read_i  input  1  read request.
REQ-008 m0_write_i, m1_write_i  input  1  write request.
REQ-009 m0_addr_i, m1_addr_i  input  ADDR_WIDTH  request address.
REQ-010 m0_data_i, m1_data_i  input  DATA_WIDTH  write data.
REQ-011 m0_ready_o, m1_ready_o  output  1  request accepted this cycle.
REQ-012 m0_valid_o, m1_valid_o  output  1  one-cycle response pulse.
REQ-013 m0_data_o, m1_data_o  output  DATA_WIDTH  response data, qualified by mK_valid_o.
REQ-014 m0_error_o, m1_error_o  output  1  response is an error (timeout or illegal request), qualified by mK_valid_o.
REQ-015 s_valid_o, s_read_o, s_write_o  output  1 each  slave request strobes.
REQ-016 s_addr_o  output  ADDR_WIDTH; s_data_o  output  DATA_WIDTH  slave request address/data.
REQ-017 s_valid_i  input  1; s_data_i  input  DATA_WIDTH  slave response, as returned by the W0RM memory/GPIO bus extender tree.

Function
REQ-018 FSM states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at most.
REQ-019 IDLE: if exactly one mK_valid_i high, grant K; if both high, grant the master not granted last (round-robin).
REQ-020 mK_ready_o is combinational: high only in IDLE for the granted master; request fields captured into registers on that edge; next state ISSUE.
REQ-021 Request with read_i==write_i (both or neither) is accepted, never issued to slave; next state RESP with error=1, data=0.
REQ-022 ISSUE: s_valid_o=1 for exactly one cycle with registered read/write/addr/data; next state WAIT; s_* strobes 0 in all other states.
REQ-023 WAIT: on s_valid_i, capture s_data_i, error=0, go RESP; s_valid_i in any state other than WAIT is ignored.
REQ-024 WAIT: 8-bit counter cleared on entry, increments per cycle; at count == TIMEOUT-1 without s_valid_i, go RESP with error=1, data=0; s_valid_i in that same cycle wins (normal response).
REQ-025 RESP: mK_valid_o=1 for one cycle for the granted master only, with registered data/error; other master's outputs 0; next state IDLE.
REQ-026 Latency: ready at cycle T, s_valid_o at T+1, slave response at T+1+N (N>=1), mK_valid_o at T+2+N; next grant possible at T+3+N.
REQ-027 mK_data_o, mK_error_o are 0 whenever mK_valid_o is 0.
REQ-028 last-granted pointer updates only on a grant; a master dropping valid before ready loses nothing and blocks nothing.

Reset
REQ-029 Asserting cpu_reset_n low, at any state including mid-transaction, forces IDLE, counter 0, last-granted=m1 (m0 wins first tie), all outputs 0, within the same cycle (asynchronous).
REQ-030 A transaction aborted by reset produces no response; a later stale s_valid_i is ignored per REQ-023.

Structure
REQ-031 Shared package w0rm_bus_pkg holds FSM state encoding, default ADDR_WIDTH/DATA_WIDTH and TIMEOUT constants.
REQ-032 One sub-module w0rm_rr_arbiter_2: 2-requester round-robin grant with last-grant register; the FSM, counter and datapath registers stay in the top module.

Verification
REQ-033 m0 read 0x8000_0000, slave responds after 1 cycle with 0x0000_00A5 -> s_valid_o at T+1, m0_valid_o at T+3, data 0xA5, error 0.
REQ-034 m0 and m1 both valid continuously for 4 transactions -> grants m0,m1,m0,m1; no back-to-back grant to same master.
REQ-035 m1 write to unmapped 0xFFFF_0000, no s_valid_i, TIMEOUT=16 -> m1_valid_o with error 1, data 0, 16 WAIT cycles after ISSUE.
REQ-036 m0 request with read=1 write=1 -> m0_ready_o, no s_valid_o, m0_valid_o next cycle with error 1.
REQ-037 Reset asserted during WAIT, slave responds 2 cycles after release -> no mK_valid_o; next m0 request completes normally.
REQ-038 s_valid_i on exactly the final timeout cycle with 0x1234 -> normal response, data 0x1234, error 0.
